// File: rtl/vp_pkg.sv
// Shared constants for the video-processing chain (crop and scaler stages).
package vp_pkg;

  localparam int DEF_X_WIDTH = 11;
  localparam int DEF_Y_WIDTH = 11;
  localparam int RGB_WIDTH   = 24;

endpackage

// File: rtl/image_scale_down_scale_dda.sv
// Single-axis Bresenham step: decides whether the current input sample is
// kept and produces the accumulator value for the next cycle. Purely
// combinational; the owner holds the accumulator register.
module scale_dda #(
  parameter int ACC_WIDTH = 11,
  parameter int NUM_WIDTH = 11
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic                 step,
  input  logic                 clear,
  input  logic [NUM_WIDTH-1:0] num,
  input  logic [ACC_WIDTH-1:0] den,
  output logic                 hit,
  output logic [ACC_WIDTH-1:0] acc_next
);

  logic [ACC_WIDTH:0] sum;

  // One extra bit so acc + num never wraps before the compare with den.
  always_comb begin
    sum      = {1'b0, acc} + (ACC_WIDTH + 1)'(num);
    hit      = (sum >= {1'b0, den});
    acc_next = acc;
    if (clear) begin
      acc_next = '0;
    end else if (step) begin
      acc_next = ACC_WIDTH'(sum - (hit ? {1'b0, den} : '0));
    end
  end

endmodule

// File: rtl/image_scale_down.sv
// Nearest-neighbour downscaler for the cropped window stream. Pixels and
// lines are decimated with one accumulator per axis, so no line buffer or
// divider is needed. An invalid configuration drops the block into a
// one-cycle-latency bypass until the next frame start.
module image_scale_down
  import vp_pkg::*;
#(
  parameter int IN_X_WIDTH  = DEF_X_WIDTH,
  parameter int IN_Y_WIDTH  = DEF_Y_WIDTH,
  parameter int OUT_X_WIDTH = DEF_X_WIDTH,
  parameter int OUT_Y_WIDTH = DEF_Y_WIDTH
) (
  input  logic                   clk_vp,
  input  logic                   rst_n,
  input  logic [IN_X_WIDTH-1:0]  in_w,
  input  logic [IN_Y_WIDTH-1:0]  in_h,
  input  logic [OUT_X_WIDTH-1:0] out_w,
  input  logic [OUT_Y_WIDTH-1:0] out_h,
  input  logic                   vs_i,
  input  logic                   de_i,
  input  logic [RGB_WIDTH-1:0]   rgb_i,
  output logic                   vs_o,
  output logic                   de_o,
  output logic [RGB_WIDTH-1:0]   rgb_o,
  output logic                   cfg_err,
  output logic                   frame_done
);

  localparam logic [IN_X_WIDTH-1:0]  X_ONE  = IN_X_WIDTH'(1);
  localparam logic [IN_Y_WIDTH-1:0]  Y_ONE  = IN_Y_WIDTH'(1);
  localparam logic [OUT_X_WIDTH-1:0] OX_ONE = OUT_X_WIDTH'(1);
  localparam logic [OUT_Y_WIDTH-1:0] OY_ONE = OUT_Y_WIDTH'(1);

  logic [IN_X_WIDTH-1:0]  in_w_q;
  logic [IN_Y_WIDTH-1:0]  in_h_q;
  logic [OUT_X_WIDTH-1:0] out_w_q;
  logic [OUT_Y_WIDTH-1:0] out_h_q;

  logic [IN_X_WIDTH-1:0]  x_cnt;
  logic [IN_Y_WIDTH-1:0]  y_cnt;
  logic [IN_X_WIDTH-1:0]  x_acc;
  logic [IN_Y_WIDTH-1:0]  y_acc;
  logic [IN_X_WIDTH-1:0]  x_acc_next;
  logic [IN_Y_WIDTH-1:0]  y_acc_next;
  logic [OUT_X_WIDTH-1:0] out_x;
  logic [OUT_Y_WIDTH-1:0] out_y;

  logic armed;
  logic last_emit;
  logic h_hit;
  logic keep_line;
  logic cfg_bad;
  logic pix_step;
  logic line_end;
  logic emit;
  logic last_pix_of_line;
  logic last_line;

  // Configuration check on the values about to be latched at frame start.
  always_comb begin
    cfg_bad = (in_w == '0) | (in_h == '0) | (out_w == '0) | (out_h == '0) |
              (32'(out_w) > 32'(in_w)) | (32'(out_h) > 32'(in_h));
  end

  // Per-cycle qualifiers: counters only move on valid pixels of in-range lines.
  always_comb begin
    pix_step         = armed & ~cfg_err & ~vs_i & de_i & (y_cnt < in_h_q);
    line_end         = pix_step & (x_cnt == in_w_q - X_ONE);
    emit             = pix_step & keep_line & h_hit;
    last_pix_of_line = (out_x == out_w_q - OX_ONE);
    last_line        = (out_y == out_h_q - OY_ONE);
  end

  scale_dda #(
    .ACC_WIDTH (IN_X_WIDTH),
    .NUM_WIDTH (OUT_X_WIDTH)
  ) u_dda_x (
    .acc      (x_acc),
    .step     (pix_step),
    .clear    (vs_i | line_end),
    .num      (out_w_q),
    .den      (in_w_q),
    .hit      (h_hit),
    .acc_next (x_acc_next)
  );

  // The vertical hit at the current accumulator is exactly "keep this line":
  // it is the keep decision the previous line end looked ahead to, and at
  // frame start (y_acc = 0) it reduces to out_h >= in_h.
  scale_dda #(
    .ACC_WIDTH (IN_Y_WIDTH),
    .NUM_WIDTH (OUT_Y_WIDTH)
  ) u_dda_y (
    .acc      (y_acc),
    .step     (line_end),
    .clear    (vs_i),
    .num      (out_h_q),
    .den      (in_h_q),
    .hit      (keep_line),
    .acc_next (y_acc_next)
  );

  // Frame-start latch, input/output counters and registered output stage.
  always_ff @(posedge clk_vp) begin
    if (!rst_n) begin
      in_w_q     <= '0;
      in_h_q     <= '0;
      out_w_q    <= '0;
      out_h_q    <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      x_acc      <= '0;
      y_acc      <= '0;
      out_x      <= '0;
      out_y      <= '0;
      armed      <= 1'b0;
      last_emit  <= 1'b0;
      vs_o       <= 1'b0;
      de_o       <= 1'b0;
      rgb_o      <= '0;
      cfg_err    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      vs_o       <= vs_i;
      frame_done <= last_emit;
      x_acc      <= x_acc_next;
      y_acc      <= y_acc_next;
      if (vs_i) begin
        armed     <= 1'b1;
        in_w_q    <= in_w;
        in_h_q    <= in_h;
        out_w_q   <= out_w;
        out_h_q   <= out_h;
        cfg_err   <= cfg_bad;
        x_cnt     <= '0;
        y_cnt     <= '0;
        out_x     <= '0;
        out_y     <= '0;
        de_o      <= 1'b0;
        rgb_o     <= '0;
        last_emit <= 1'b0;
      end else begin
        if (cfg_err) begin
          de_o      <= armed & de_i;
          rgb_o     <= (armed & de_i) ? rgb_i : '0;
          last_emit <= 1'b0;
        end else begin
          de_o      <= emit;
          rgb_o     <= emit ? rgb_i : '0;
          last_emit <= emit & last_pix_of_line & last_line;
        end
        if (line_end) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + Y_ONE;
        end else if (pix_step) begin
          x_cnt <= x_cnt + X_ONE;
        end
        if (emit) begin
          if (last_pix_of_line) begin
            out_x <= '0;
            out_y <= out_y + OY_ONE;
          end else begin
            out_x <= out_x + OX_ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_image_scale_down.sv
// Directed bench for image_scale_down: streams small frames with
// hand-derived kept-pixel masks and checks every output cycle.
module tb_image_scale_down;

  logic        clk_vp = 1'b0;
  logic        rst_n;
  logic [10:0] in_w, in_h, out_w, out_h;
  logic        vs_i, de_i;
  logic [23:0] rgb_i;
  logic        vs_o, de_o, cfg_err, frame_done;
  logic [23:0] rgb_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int   f_emit, f_bad, f_done_cnt, f_done_t, f_last_t, f_bad_x, f_bad_y;
  logic f_vs, f_cfg;

  always #5 clk_vp = ~clk_vp;

  image_scale_down dut (
    .clk_vp     (clk_vp),
    .rst_n      (rst_n),
    .in_w       (in_w),
    .in_h       (in_h),
    .out_w      (out_w),
    .out_h      (out_h),
    .vs_i       (vs_i),
    .de_i       (de_i),
    .rgb_i      (rgb_i),
    .vs_o       (vs_o),
    .de_o       (de_o),
    .rgb_o      (rgb_o),
    .cfg_err    (cfg_err),
    .frame_done (frame_done)
  );

  // Drive one cycle of inputs on the falling edge, sample just after the rising edge.
  task automatic tick(input logic rst, input logic vs, input logic de, input logic [23:0] rgb);
    @(negedge clk_vp);
    rst_n = rst;
    vs_i  = vs;
    de_i  = de;
    rgb_i = rgb;
    @(posedge clk_vp);
    #1;
    cyc++;
  endtask

  task automatic set_cfg(input int iw, input int ih, input int ow, input int oh);
    in_w  = 11'(iw);
    in_h  = 11'(ih);
    out_w = 11'(ow);
    out_h = 11'(oh);
  endtask

  // Accumulates per-cycle observations of the output stage for one frame.
  task automatic record_cycle(input logic exp_de, input logic [23:0] exp_rgb, input int x, input int y);
    logic [23:0] want;
    want = exp_de ? exp_rgb : 24'h0;
    if (de_o !== exp_de || rgb_o !== want) begin
      if (f_bad == 0) begin
        f_bad_x = x;
        f_bad_y = y;
      end
      f_bad++;
    end
    if (de_o === 1'b1) begin
      f_emit++;
      f_last_t = cyc;
    end
    if (frame_done === 1'b1) begin
      f_done_cnt++;
      f_done_t = cyc;
    end
  endtask

  // Streams one frame: vs pulse, then lines of w pixels with 2 idle cycles after each.
  task automatic send_frame(input int w, input int lines, input logic [15:0] mx, input logic [15:0] my,
                            input bit bypass, input bit vs_de, input int rst_line, input int chg_line,
                            input int chg_w, input bit gap, input logic [23:0] base);
    logic [23:0] rgb;
    logic        exp;
    logic        rst_seen;
    logic        rst_now;
    f_emit = 0; f_bad = 0; f_done_cnt = 0; f_done_t = -1; f_last_t = -1;
    f_bad_x = -1; f_bad_y = -1;
    rst_seen = 1'b0;
    tick(1'b1, 1'b1, vs_de, 24'h123456);
    f_vs  = vs_o;
    f_cfg = cfg_err;
    record_cycle(1'b0, 24'h0, -1, -1);
    for (int y = 0; y < lines; y++) begin
      if (y == chg_line) out_w = 11'(chg_w);
      for (int x = 0; x < w; x++) begin
        rst_now = (y == rst_line) && (x == 0);
        if (rst_now) rst_seen = 1'b1;
        rgb = base ^ {y[11:0], x[11:0]};
        exp = bypass ? 1'b1 : (mx[x] & my[y] & ~rst_seen);
        tick(~rst_now, 1'b0, 1'b1, rgb);
        record_cycle(exp, rgb, x, y);
        if (gap && x == 2) begin
          tick(1'b1, 1'b0, 1'b0, 24'hFFFFFF);
          record_cycle(1'b0, 24'h0, x, y);
        end
      end
      for (int i = 0; i < 2; i++) begin
        tick(1'b1, 1'b0, 1'b0, 24'h0);
        record_cycle(1'b0, 24'h0, w, y);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b0, 1'b0, 24'h0);
      record_cycle(1'b0, 24'h0, -1, lines);
    end
  endtask

  task automatic test_reset();
    int seen;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 24'h0);
    checks++; if (vs_o !== 1'b0) begin errors++; $display("FAIL reset vs_o: got %b, expected 0", vs_o); end
    checks++; if (de_o !== 1'b0) begin errors++; $display("FAIL reset de_o: got %b, expected 0", de_o); end
    checks++; if (rgb_o !== 24'h0) begin errors++; $display("FAIL reset rgb_o: got %h, expected 000000", rgb_o); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset cfg_err: got %b, expected 0", cfg_err); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset frame_done: got %b, expected 0", frame_done); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 1'b1, 24'hABCDEF);
      if (de_o !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL unarmed de_o: got %0d active cycles, expected 0", seen); end
  endtask

  task automatic test_scale_8x4();
    set_cfg(8, 4, 4, 2);
    // Fifth input line lies beyond in_h and must be ignored.
    send_frame(8, 5, 16'h00AA, 16'h000A, 1'b0, 1'b0, -1, -1, 0, 1'b0, 24'h000000);
    checks++; if (f_vs !== 1'b1) begin errors++; $display("FAIL 8x4 vs_o: got %b, expected 1", f_vs); end
    checks++; if (f_cfg !== 1'b0) begin errors++; $display("FAIL 8x4 cfg_err: got %b, expected 0", f_cfg); end
    checks++; if (f_bad !== 0) begin errors++; $display("FAIL 8x4 pixels: got %0d bad cycles (first x=%0d y=%0d), expected 0", f_bad, f_bad_x, f_bad_y); end
    checks++; if (f_emit !== 8) begin errors++; $display("FAIL 8x4 count: got %0d, expected 8", f_emit); end
    checks++; if (f_done_cnt !== 1) begin errors++; $display("FAIL 8x4 frame_done pulses: got %0d, expected 1", f_done_cnt); end
    checks++; if (f_done_t !== f_last_t + 1) begin errors++; $display("FAIL 8x4 frame_done time: got %0d, expected %0d", f_done_t, f_last_t + 1); end
  endtask

  task automatic test_scale_6x6();
    set_cfg(6, 6, 4, 6);
    // Includes a de_i gap after x=2 on every line.
    send_frame(6, 6, 16'h0036, 16'h003F, 1'b0, 1'b0, -1, -1, 0, 1'b1, 24'h5A0000);
    checks++; if (f_bad !== 0) begin errors++; $display("FAIL 6x6 pixels: got %0d bad cycles (first x=%0d y=%0d), expected 0", f_bad, f_bad_x, f_bad_y); end
    checks++; if (f_emit !== 24) begin errors++; $display("FAIL 6x6 count: got %0d, expected 24", f_emit); end
    checks++; if (f_done_cnt !== 1) begin errors++; $display("FAIL 6x6 frame_done pulses: got %0d, expected 1", f_done_cnt); end
    checks++; if (f_done_t !== f_last_t + 1) begin errors++; $display("FAIL 6x6 frame_done time: got %0d, expected %0d", f_done_t, f_last_t + 1); end
  endtask

  task automatic test_cfg_err();
    set_cfg(8, 4, 9, 4);
    send_frame(8, 4, 16'h0000, 16'h0000, 1'b1, 1'b0, -1, -1, 0, 1'b0, 24'hC30000);
    checks++; if (f_cfg !== 1'b1) begin errors++; $display("FAIL bypass cfg_err: got %b, expected 1", f_cfg); end
    checks++; if (f_bad !== 0) begin errors++; $display("FAIL bypass pixels: got %0d bad cycles (first x=%0d y=%0d), expected 0", f_bad, f_bad_x, f_bad_y); end
    checks++; if (f_emit !== 32) begin errors++; $display("FAIL bypass count: got %0d, expected 32", f_emit); end
  endtask

  task automatic test_identity();
    set_cfg(8, 4, 8, 4);
    send_frame(8, 4, 16'h00FF, 16'h000F, 1'b0, 1'b0, -1, -1, 0, 1'b0, 24'h0F0000);
    checks++; if (f_cfg !== 1'b0) begin errors++; $display("FAIL identity cfg_err: got %b, expected 0", f_cfg); end
    checks++; if (f_bad !== 0) begin errors++; $display("FAIL identity pixels: got %0d bad cycles (first x=%0d y=%0d), expected 0", f_bad, f_bad_x, f_bad_y); end
    checks++; if (f_emit !== 32) begin errors++; $display("FAIL identity count: got %0d, expected 32", f_emit); end
    checks++; if (f_done_t !== f_last_t + 1) begin errors++; $display("FAIL identity frame_done time: got %0d, expected %0d", f_done_t, f_last_t + 1); end
  endtask

  task automatic test_midframe_cfg();
    set_cfg(8, 4, 4, 2);
    send_frame(8, 4, 16'h00AA, 16'h000A, 1'b0, 1'b0, -1, 1, 2, 1'b0, 24'h330000);
    checks++; if (f_bad !== 0) begin errors++; $display("FAIL cfg-change old frame pixels: got %0d bad cycles (first x=%0d y=%0d), expected 0", f_bad, f_bad_x, f_bad_y); end
    checks++; if (f_emit !== 8) begin errors++; $display("FAIL cfg-change old frame count: got %0d, expected 8", f_emit); end
    send_frame(8, 4, 16'h0088, 16'h000A, 1'b0, 1'b0, -1, -1, 0, 1'b0, 24'h440000);
    checks++; if (f_bad !== 0) begin errors++; $display("FAIL cfg-change new frame pixels: got %0d bad cycles (first x=%0d y=%0d), expected 0", f_bad, f_bad_x, f_bad_y); end
    checks++; if (f_emit !== 4) begin errors++; $display("FAIL cfg-change new frame count: got %0d, expected 4", f_emit); end
  endtask

  task automatic test_midframe_reset();
    set_cfg(8, 4, 4, 2);
    send_frame(8, 4, 16'h00AA, 16'h000A, 1'b0, 1'b0, 2, -1, 0, 1'b0, 24'h660000);
    checks++; if (f_bad !== 0) begin errors++; $display("FAIL reset-frame pixels: got %0d bad cycles (first x=%0d y=%0d), expected 0", f_bad, f_bad_x, f_bad_y); end
    checks++; if (f_emit !== 4) begin errors++; $display("FAIL reset-frame count: got %0d, expected 4", f_emit); end
    checks++; if (f_done_cnt !== 0) begin errors++; $display("FAIL reset-frame frame_done pulses: got %0d, expected 0", f_done_cnt); end
    // Recovery frame whose vs pulse carries a pixel that must be dropped.
    send_frame(8, 4, 16'h00AA, 16'h000A, 1'b0, 1'b1, -1, -1, 0, 1'b0, 24'h770000);
    checks++; if (f_bad !== 0) begin errors++; $display("FAIL recovery pixels: got %0d bad cycles (first x=%0d y=%0d), expected 0", f_bad, f_bad_x, f_bad_y); end
    checks++; if (f_emit !== 8) begin errors++; $display("FAIL recovery count: got %0d, expected 8", f_emit); end
    checks++; if (f_done_cnt !== 1) begin errors++; $display("FAIL recovery frame_done pulses: got %0d, expected 1", f_done_cnt); end
  endtask

  initial begin
    rst_n = 1'b0;
    vs_i  = 1'b0;
    de_i  = 1'b0;
    rgb_i = 24'h0;
    set_cfg(8, 4, 4, 2);
    test_reset();
    test_scale_8x4();
    test_scale_6x6();
    test_cfg_err();
    test_identity();
    test_midframe_cfg();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_scale_down.md
Name: image_scale_down

Overview:
- Downstream stage of the crop block. Consumes the cropped window stream (vs pulse, de, 24-bit RGB) on clk_vp.
- Produces an integer-ratio-free nearest-neighbour downscaled stream of out_w x out_h pixels for the frame-buffer writer.
- Decimates pixels and lines with a division-free accumulator (Bresenham) per axis. No line buffer is needed.

Parameters:
- IN_X_WIDTH, 11, width of in_w and of the horizontal input counter.
- IN_Y_WIDTH, 11, width of in_h and of the vertical input counter.
- OUT_X_WIDTH, 11, width of out_w and of the horizontal output counter.
- OUT_Y_WIDTH, 11, width of out_h and of the output line counter.

Ports:
- clk_vp  in  1  video-processing clock
- rst_n  in  1  synchronous, active-low reset
- in_w  in  IN_X_WIDTH  input window width (crop end_x - start_x)
- in_h  in  IN_Y_WIDTH  input window height
- out_w  in  OUT_X_WIDTH  target width
- out_h  in  OUT_Y_WIDTH  target height
- vs_i  in  1  single-cycle frame-start pulse
- de_i  in  1  input pixel valid
- rgb_i  in  24  input pixel
- vs_o  out  1  frame-start pulse, vs_i delayed 1 cycle
- de_o  out  1  output pixel valid
- rgb_o  out  24  output pixel, 0 when de_o=0
- cfg_err  out  1  latched configuration invalid, block in bypass
- frame_done  out  1  1-cycle pulse after the last output pixel of the frame

Behaviour:
- Reset is decided as: rst_n synchronous, active-low; clock clk_vp.
- Reset state: vs_o=0, de_o=0, rgb_o=0, cfg_err=0, frame_done=0. All counters and accumulators are 0. armed=0.
- While armed=0, de_o stays 0. The first vs_i after reset sets armed=1.
- On vs_i, the block latches in_w, in_h, out_w and out_h. Configuration changes mid-frame are ignored until the next vs_i.
- On vs_i, the block clears x_cnt, y_cnt, x_acc, y_acc and the output line counter, and sets keep_line = (out_h >= in_h).
- cfg_err = (in_w==0) | (in_h==0) | (out_w==0) | (out_h==0) | (out_w>in_w) | (out_h>in_h). It is evaluated on the latched values and updated at vs_i.
- When cfg_err=1, the block runs in bypass: de_o/rgb_o = de_i/rgb_i registered, with latency 1.
- Horizontal axis, on each de_i cycle:
  - hit = (x_acc + out_w >= in_w), computed at IN_X_WIDTH+1 bits.
  - If hit: x_acc <= x_acc + out_w - in_w. Otherwise: x_acc <= x_acc + out_w.
  - x_cnt increments.
- Line end is when de_i and x_cnt==in_w-1. At line end:
  - x_cnt and x_acc are cleared.
  - The vertical accumulator steps the same way with out_h/in_h: y_acc advances, and keep_line for the next line = (y_acc_next + out_h >= in_h).
  - y_cnt increments.
- Emit: de_o <= armed & de_i & keep_line & hit & (y_cnt < in_h). rgb_o <= rgb_i on emit, else 0. Latency is 1 cycle.
- Exactly out_w pixels are emitted per kept line, and exactly out_h lines per frame. The last input pixel and the last input line are always kept.
- Input lines with y_cnt >= in_h are ignored: no emit, and counters are held.
- frame_done pulses on the cycle after the emitted pixel that completes output line out_h.
- If vs_i and de_i occur together, vs_i wins: the pixel is dropped and all counters are cleared.
- vs_o <= vs_i every cycle, independent of armed.
- Reset asserted mid-frame: outputs clear on the next edge. No output until a fresh vs_i.
- de_i gaps inside a line (de low) freeze all counters.

Decomposition:
- Shared package vp_pkg holds the default width constants (11) and the RGB width (24), reused by the crop and scaler stages.
- One natural sub-module, scale_dda: a single-axis accumulator.
  - Inputs: step enable, clear, num (out), den (in).
  - Outputs: hit, and the next accumulator value.
  - Instantiated twice: horizontal (per pixel) and vertical (per line end).

Test Plan:
- in 8x4 -> out 4x2, rgb_i = {y,x}: de_o pulses at input x=1,3,5,7 of input lines 1 and 3 only. Total 8 pixels. frame_done 1 cycle after the 8th.
- in 6x6 -> out 4x6: kept x = 1,2,4,5 on every line. 24 pixels. Each rgb_o appears exactly 1 cycle after its rgb_i.
- in 8x4 -> out 8x4 (identity): every pixel is passed with 1-cycle latency. cfg_err=0.
- out_w=9, in_w=8 at vs_i: cfg_err=1 from the following cycle. All 32 input pixels are passed through.
- out_w changes from 4 to 2 mid-frame: the current frame still emits 4 per line. The next frame (after vs_i) emits 2 per line.
- rst_n low for 1 cycle at input line 2: de_o=0 for the rest of the frame, even with de_i active. The next vs_i resumes normal scaling. vs_i with de_i together: that pixel is not emitted.
